// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding and default timing parameters,
// used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        DATA  = 2'd2,
        STOP  = 2'd3
    } uart_state_t;

    localparam int unsigned OS_DEFAULT          = 4;
    localparam int unsigned SYNC_STAGES_DEFAULT = 2;

    // Odd parity over a full byte fails when the count of ones is even.
    function automatic logic odd_parity_fail(input logic [7:0] b);
        return ~^b;
    endfunction

endpackage

// File: rtl/sync_2ff.sv
// Multi-flop synchronizer for a single asynchronous input bit, with a
// configurable reset value so idle-high lines come out of reset idle.
module sync_2ff #(
    parameter int unsigned STAGES  = 2,
    parameter logic        RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rstn,
    input  logic d,
    output logic q
);

    logic [STAGES-1:0] ff;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            ff <= {STAGES{RST_VAL}};
        end else begin
            ff[0] <= d;
            for (int unsigned i = 1; i < STAGES; i++) begin
                ff[i] <= ff[i-1];
            end
        end
    end

    assign q = ff[STAGES-1];

endmodule

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 8N1 or 7 data bits + odd parity, with framing
// error, overrun detection and a valid/ack handshake toward the consumer.
module uart_rx
    import uart_pkg::*;
#(
    parameter int unsigned OS          = OS_DEFAULT,
    parameter int unsigned SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic       clk,
    input  logic       rstn,
    input  logic       b_tick,
    input  logic       rx,
    input  logic       parity_check,
    input  logic       rx_ack,
    output logic [7:0] rx_data,
    output logic       rx_valid,
    output logic       rx_done,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overrun
);

    localparam int unsigned CW = $clog2(OS);
    localparam logic [CW-1:0] HALF_LAST = CW'(OS/2 - 1);
    localparam logic [CW-1:0] BIT_LAST  = CW'(OS - 1);

    logic rxs;
    logic rxs_d;

    uart_state_t   state, state_n;
    logic [CW-1:0] cnt, cnt_n;
    logic [2:0]    bits, bits_n;
    logic [7:0]    shreg, shreg_n;
    logic          pc_lat, pc_n;
    logic          sample_stop;
    logic          done_pend;
    logic          stop_bit;

    sync_2ff #(
        .STAGES  (SYNC_STAGES),
        .RST_VAL (1'b1)
    ) u_sync (
        .clk  (clk),
        .rstn (rstn),
        .d    (rx),
        .q    (rxs)
    );

    always_comb begin
        state_n     = state;
        cnt_n       = cnt;
        bits_n      = bits;
        shreg_n     = shreg;
        pc_n        = pc_lat;
        sample_stop = 1'b0;
        case (state)
            IDLE: begin
                if (rxs_d && !rxs) begin
                    state_n = START;
                    cnt_n   = '0;
                    pc_n    = parity_check;
                end
            end
            START: begin
                if (b_tick) begin
                    if (cnt == HALF_LAST) begin
                        if (!rxs) begin
                            state_n = DATA;
                            cnt_n   = '0;
                            bits_n  = '0;
                        end else begin
                            state_n = IDLE;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            DATA: begin
                if (b_tick) begin
                    if (cnt == BIT_LAST) begin
                        shreg_n = {rxs, shreg[7:1]};
                        cnt_n   = '0;
                        if (bits == 3'd7) begin
                            state_n = STOP;
                        end else begin
                            bits_n = bits + 1'b1;
                        end
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            STOP: begin
                // Leave at mid-stop so a start edge in its second half is caught.
                if (b_tick) begin
                    if (cnt == BIT_LAST) begin
                        sample_stop = 1'b1;
                        state_n     = IDLE;
                    end else begin
                        cnt_n = cnt + 1'b1;
                    end
                end
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state     <= IDLE;
            cnt       <= '0;
            bits      <= '0;
            shreg     <= '0;
            pc_lat    <= 1'b0;
            rxs_d     <= 1'b1;
            done_pend <= 1'b0;
            stop_bit  <= 1'b1;
        end else begin
            state     <= state_n;
            cnt       <= cnt_n;
            bits      <= bits_n;
            shreg     <= shreg_n;
            pc_lat    <= pc_n;
            rxs_d     <= rxs;
            done_pend <= sample_stop;
            if (sample_stop) begin
                stop_bit <= rxs;
            end
        end
    end

    // Completion lands one clk after the stop sample; shreg cannot change in between.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rx_data    <= '0;
            rx_valid   <= 1'b0;
            rx_done    <= 1'b0;
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overrun    <= 1'b0;
        end else begin
            rx_done <= done_pend;
            if (done_pend) begin
                rx_data    <= pc_lat ? {1'b0, shreg[6:0]} : shreg;
                parity_err <= pc_lat & odd_parity_fail(shreg);
                frame_err  <= ~stop_bit;
                rx_valid   <= 1'b1;
                if (rx_ack) begin
                    overrun <= 1'b0;
                end else if (rx_valid) begin
                    overrun <= 1'b1;
                end
            end else if (rx_ack) begin
                rx_valid <= 1'b0;
                overrun  <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: table of single frames plus hand-written
// sequences for glitch, break, overrun/ack and mid-frame reset.
`timescale 1ns/1ps
module tb_uart_rx;
    import uart_pkg::*;

    localparam int unsigned OS       = 4;
    localparam int unsigned TICK_DIV = 4;
    localparam int unsigned BIT_CLKS = OS * TICK_DIV;

    logic       clk = 1'b0;
    logic       rstn = 1'b0;
    logic       b_tick;
    logic       rx = 1'b1;
    logic       parity_check = 1'b0;
    logic       rx_ack = 1'b0;
    logic [7:0] rx_data;
    logic       rx_valid, rx_done, parity_err, frame_err, overrun;

    int unsigned n_vec = 0;
    int unsigned n_miss = 0;
    int unsigned done_cnt = 0;
    int unsigned tick_cnt = 0;
    int unsigned d0;
    bit          ack_arm = 1'b0;

    typedef struct {
        logic [7:0] line;
        logic       pc;
        logic       stop;
        logic [7:0] exp_data;
        logic       exp_pe;
        logic       exp_fe;
    } vec_t;

    vec_t vecs[8];

    uart_rx #(.OS(OS), .SYNC_STAGES(2)) dut (
        .clk          (clk),
        .rstn         (rstn),
        .b_tick       (b_tick),
        .rx           (rx),
        .parity_check (parity_check),
        .rx_ack       (rx_ack),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .rx_done      (rx_done),
        .parity_err   (parity_err),
        .frame_err    (frame_err),
        .overrun      (overrun)
    );

    always #5 clk = ~clk;

    always @(posedge clk) tick_cnt <= (tick_cnt + 1) % TICK_DIV;
    assign b_tick = (tick_cnt == TICK_DIV - 1);

    always @(negedge clk) if (rx_done) done_cnt++;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic step(input int unsigned n);
        repeat (n) begin
            @(negedge clk);
            if (ack_arm) rx_ack = dut.done_pend;
        end
    endtask

    task automatic send_bits(input logic [7:0] b, input int unsigned nbits);
        rx = 1'b0;
        step(BIT_CLKS);
        for (int unsigned i = 0; i < nbits; i++) begin
            rx = b[i];
            step(BIT_CLKS);
        end
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_v);
        send_bits(b, 8);
        rx = stop_v;
        step(BIT_CLKS);
        rx = 1'b1;
        step(BIT_CLKS);
    endtask

    task automatic ack_pulse();
        rx_ack = 1'b1;
        step(1);
        rx_ack = 1'b0;
        step(1);
    endtask

    initial begin
        vecs[0] = '{8'h55, 1'b0, 1'b1, 8'h55, 1'b0, 1'b0};
        vecs[1] = '{8'hC1, 1'b1, 1'b1, 8'h41, 1'b0, 1'b0};
        vecs[2] = '{8'h41, 1'b1, 1'b1, 8'h41, 1'b1, 1'b0};
        vecs[3] = '{8'hA3, 1'b0, 1'b1, 8'hA3, 1'b0, 1'b0};
        vecs[4] = '{8'h3C, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1};
        vecs[5] = '{8'h80, 1'b1, 1'b1, 8'h00, 1'b0, 1'b0};
        vecs[6] = '{8'hFE, 1'b1, 1'b1, 8'h7E, 1'b0, 1'b0};
        vecs[7] = '{8'h00, 1'b1, 1'b1, 8'h00, 1'b1, 1'b0};

        step(4);
        check("rst.rx_data", rx_data, 0);
        check("rst.rx_valid", rx_valid, 0);
        check("rst.rx_done", rx_done, 0);
        check("rst.parity_err", parity_err, 0);
        check("rst.frame_err", frame_err, 0);
        check("rst.overrun", overrun, 0);
        rstn = 1'b1;
        step(BIT_CLKS);

        foreach (vecs[i]) begin
            parity_check = vecs[i].pc;
            d0 = done_cnt;
            send_frame(vecs[i].line, vecs[i].stop);
            check($sformatf("v%0d.done_cnt", i), done_cnt - d0, 1);
            check($sformatf("v%0d.rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("v%0d.parity_err", i), parity_err, vecs[i].exp_pe);
            check($sformatf("v%0d.frame_err", i), frame_err, vecs[i].exp_fe);
            check($sformatf("v%0d.rx_valid", i), rx_valid, 1);
            check($sformatf("v%0d.overrun", i), overrun, 0);
            ack_pulse();
            check($sformatf("v%0d.valid_after_ack", i), rx_valid, 0);
        end

        // One-tick glitch: false start, then a clean frame.
        parity_check = 1'b0;
        d0 = done_cnt;
        rx = 1'b0;
        step(TICK_DIV);
        rx = 1'b1;
        step(4 * TICK_DIV);
        check("glitch.state", dut.state, IDLE);
        step(BIT_CLKS);
        check("glitch.no_done", done_cnt - d0, 0);
        send_frame(8'hA3, 1'b1);
        check("glitch.done_cnt", done_cnt - d0, 1);
        check("glitch.rx_data", rx_data, 8'hA3);
        ack_pulse();

        // Break: stop bit low, line held low afterwards.
        d0 = done_cnt;
        send_bits(8'h3C, 8);
        rx = 1'b0;
        step(5 * BIT_CLKS);
        check("break.done_cnt", done_cnt - d0, 1);
        check("break.rx_data", rx_data, 8'h3C);
        check("break.frame_err", frame_err, 1);
        rx = 1'b1;
        step(2 * BIT_CLKS);
        check("break.single_frame", done_cnt - d0, 1);
        ack_pulse();

        // Overrun, ack clear, then ack coincident with completion.
        d0 = done_cnt;
        send_frame(8'h11, 1'b1);
        send_frame(8'h22, 1'b1);
        check("ovr.done_cnt", done_cnt - d0, 2);
        check("ovr.rx_data", rx_data, 8'h22);
        check("ovr.overrun", overrun, 1);
        check("ovr.rx_valid", rx_valid, 1);
        ack_pulse();
        check("ovr.ack_valid", rx_valid, 0);
        check("ovr.ack_overrun", overrun, 0);
        ack_arm = 1'b1;
        send_frame(8'h33, 1'b1);
        ack_arm = 1'b0;
        rx_ack = 1'b0;
        step(1);
        check("ovr.coinc_done_cnt", done_cnt - d0, 3);
        check("ovr.coinc_valid", rx_valid, 1);
        check("ovr.coinc_data", rx_data, 8'h33);
        check("ovr.coinc_overrun", overrun, 0);
        ack_pulse();

        // Reset during data bit 4 with valid and overrun set beforehand.
        send_frame(8'h5A, 1'b1);
        send_frame(8'hA5, 1'b1);
        check("mrst.pre_overrun", overrun, 1);
        d0 = done_cnt;
        send_bits(8'h7E, 4);
        rx = 1'b1;
        step(BIT_CLKS / 2);
        rstn = 1'b0;
        step(2);
        check("mrst.rx_data", rx_data, 0);
        check("mrst.rx_valid", rx_valid, 0);
        check("mrst.rx_done", rx_done, 0);
        check("mrst.parity_err", parity_err, 0);
        check("mrst.frame_err", frame_err, 0);
        check("mrst.overrun", overrun, 0);
        rstn = 1'b1;
        step(3 * BIT_CLKS);
        check("mrst.no_done", done_cnt - d0, 0);
        check("mrst.state", dut.state, IDLE);
        send_frame(8'h7E, 1'b1);
        check("mrst.done_cnt", done_cnt - d0, 1);
        check("mrst.rx_data_7e", rx_data, 8'h7E);
        check("mrst.rx_valid_7e", rx_valid, 1);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
